// File: rtl/polaris_fetch_queue_if.sv
// polaris_fetch_queue_if: instruction bus, instruction stream and redirect signals of the fetch queue
interface polaris_fetch_queue_if #(
  parameter int XLEN = 64,
  parameter int DEPTH = 4
);
  logic icyc_o;
  logic istb_o;
  logic [XLEN-1:0] iadr_o;
  logic [1:0] isiz_o;
  logic iack_i;
  logic ierr_i;
  logic [31:0] idat_i;
  logic inst_valid_o;
  logic inst_ready_i;
  logic [31:0] inst_o;
  logic [XLEN-1:0] inst_pc_o;
  logic inst_err_o;
  logic redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic [$clog2(DEPTH):0] fill_o;
  modport master (
    output icyc_o, istb_o, iadr_o, isiz_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o, fill_o,
    input iack_i, ierr_i, idat_i, inst_ready_i, redirect_i, redirect_pc_i
  );
  modport slave (
    input icyc_o, istb_o, iadr_o, isiz_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o, fill_o,
    output iack_i, ierr_i, idat_i, inst_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/polaris_fetch_queue.sv
// polaris_fetch_queue: fetch PC owner, single-outstanding I-bus master and prefetch FIFO with redirect/squash
module polaris_fetch_queue #(
  parameter int XLEN = 64,
  parameter int DEPTH = 4,
  parameter logic [63:0] RESET_VEC = 64'hFFFF_FFFF_FFFF_FF00
) (
  input logic clk_i,
  input logic reset_i,
  polaris_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] RV = RESET_VEC[XLEN-1:0];
  logic [31:0] mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc [DEPTH];
  logic [DEPTH-1:0] mem_err;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt, cnt_next;
  logic [XLEN-1:0] fpc, fpc_next, adr;
  logic busy, halt, squash, halt_next, squash_next;
  logic resp, push, pop, issue;
  always_comb begin
    resp = busy & (bus.iack_i | bus.ierr_i);
    push = resp & ~squash & ~bus.redirect_i;
    pop = bus.inst_valid_o & bus.inst_ready_i & ~bus.redirect_i;
    cnt_next = bus.redirect_i ? '0 : cnt + CW'(push) - CW'(pop);
    fpc_next = bus.redirect_i ? bus.redirect_pc_i & ~XLEN'(3) :
               (push & bus.iack_i) ? fpc + XLEN'(4) : fpc;
    halt_next = ~bus.redirect_i & (halt | (push & bus.ierr_i));
    // a redirect with a transfer still in flight must swallow that transfer's response
    squash_next = (bus.redirect_i & busy & ~resp) | (squash & ~resp);
    issue = (~busy | resp) & ~halt_next & ~squash_next & (cnt_next < CW'(DEPTH));
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy <= 1'b0;
      halt <= 1'b0;
      squash <= 1'b0;
      fpc <= RV;
      adr <= '0;
      cnt <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      busy <= issue | (busy & ~resp);
      halt <= halt_next;
      squash <= squash_next;
      fpc <= fpc_next;
      cnt <= cnt_next;
      if (issue) adr <= fpc_next;
      wptr <= bus.redirect_i ? '0 : wptr + AW'(push);
      rptr <= bus.redirect_i ? '0 : rptr + AW'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_inst[wptr] <= bus.ierr_i ? 32'd0 : bus.idat_i;
      mem_pc[wptr] <= adr;
      mem_err[wptr] <= bus.ierr_i;
    end
  end
  assign bus.icyc_o = busy;
  assign bus.istb_o = busy;
  assign bus.iadr_o = busy ? adr : '0;
  assign bus.isiz_o = busy ? 2'b10 : 2'b00;
  assign bus.inst_valid_o = cnt != '0;
  assign bus.inst_o = bus.inst_valid_o ? mem_inst[rptr] : '0;
  assign bus.inst_pc_o = bus.inst_valid_o ? mem_pc[rptr] : '0;
  assign bus.inst_err_o = bus.inst_valid_o & mem_err[rptr];
  assign bus.fill_o = cnt;
endmodule

// File: tb/tb_polaris_fetch_queue.sv
// tb_polaris_fetch_queue: vector table plus scoreboarded bus/consumer model for the fetch queue
module tb_polaris_fetch_queue;
  localparam logic [63:0] H = 64'hFFFF_FFFF_FFFF_FF00;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst32 = 1'b1;
  always #5 clk = ~clk;
  polaris_fetch_queue_if #(.XLEN(64), .DEPTH(4)) f64 ();
  polaris_fetch_queue_if #(.XLEN(32), .DEPTH(4)) f32 ();
  polaris_fetch_queue #(.XLEN(64), .DEPTH(4)) u64 (.clk_i(clk), .reset_i(rst), .bus(f64.master));
  polaris_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_VEC(64'hFFFF_FFF8)) u32 (
    .clk_i(clk), .reset_i(rst32), .bus(f32.master));
  typedef struct {
    logic rst, ack, rdy;
    logic [31:0] dat;
    logic e_istb;
    logic [63:0] e_iadr;
    logic e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    logic [2:0] e_fill;
  } vec_t;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic err;
  } ent_t;
  vec_t tv [7];
  ent_t sb [$];
  logic [63:0] mpc;
  int w;
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    f64.iack_i = 1'b0;
    f64.ierr_i = 1'b0;
    f64.idat_i = '0;
    f64.inst_ready_i = 1'b0;
    f64.redirect_i = 1'b0;
    f64.redirect_pc_i = '0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    mpc = H;
    w = 0;
  endtask
  // zero/multi-wait slave answering with the low word of the expected fetch PC
  task automatic bus_step(int ws);
    f64.iack_i = 1'b0;
    f64.ierr_i = 1'b0;
    f64.idat_i = '0;
    if (f64.istb_o) begin
      chk("iadr", f64.iadr_o, mpc);
      if (w >= ws) begin
        f64.iack_i = 1'b1;
        f64.idat_i = mpc[31:0];
        sb.push_back('{mpc, mpc[31:0], 1'b0});
        mpc += 4;
        w = 0;
      end else w++;
    end
  endtask
  task automatic pop_step(logic rdy);
    ent_t e;
    f64.inst_ready_i = rdy;
    if (rdy && f64.inst_valid_o) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underflow: popped pc %0h with no expected entry", f64.inst_pc_o);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", f64.inst_pc_o, e.pc);
        chk("pop_inst", f64.inst_o, e.inst);
        chk("pop_err", f64.inst_err_o, e.err);
      end
    end
  endtask
  task automatic step(int ws, logic rdy);
    bus_step(ws);
    pop_step(rdy);
    tick();
  endtask
  initial begin
    int cnt;
    idle();
    f32.iack_i = 1'b0;
    f32.ierr_i = 1'b0;
    f32.idat_i = '0;
    f32.inst_ready_i = 1'b0;
    f32.redirect_i = 1'b0;
    f32.redirect_pc_i = '0;
    tv[0] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0, 3'd0};
    tv[1] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 64'h0, 1'b0, 64'h0, 32'h0, 3'd0};
    tv[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, H, 1'b0, 64'h0, 32'h0, 3'd0};
    tv[3] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF00, 1'b1, H + 4, 1'b1, H, 32'hFFFF_FF00, 3'd1};
    tv[4] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF04, 1'b1, H + 8, 1'b1, H + 4, 32'hFFFF_FF04, 3'd1};
    tv[5] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF08, 1'b1, H + 12, 1'b1, H + 8, 32'hFFFF_FF08, 3'd1};
    tv[6] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, H + 12, 1'b0, 64'h0, 32'h0, 3'd0};
    for (int i = 0; i < 7; i++) begin
      rst = tv[i].rst;
      f64.iack_i = tv[i].ack;
      f64.idat_i = tv[i].dat;
      f64.inst_ready_i = tv[i].rdy;
      tick();
      chk($sformatf("v%0d_istb", i), f64.istb_o, tv[i].e_istb);
      chk($sformatf("v%0d_iadr", i), f64.iadr_o, tv[i].e_iadr);
      chk($sformatf("v%0d_isiz", i), f64.isiz_o, tv[i].e_istb ? 2'b10 : 2'b00);
      chk($sformatf("v%0d_valid", i), f64.inst_valid_o, tv[i].e_valid);
      chk($sformatf("v%0d_pc", i), f64.inst_pc_o, tv[i].e_pc);
      chk($sformatf("v%0d_inst", i), f64.inst_o, tv[i].e_inst);
      chk($sformatf("v%0d_fill", i), f64.fill_o, tv[i].e_fill);
    end
    // random back-pressure streams, then drain with the slave stalled
    mpc = H + 12;
    w = 0;
    for (int i = 0; i < 80; i++) step(0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 80; i++) step(2, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 12; i++) step(1000, 1'b1);
    chk("drain_sb", sb.size(), 0);
    chk("drain_fill", f64.fill_o, 0);
    // full queue stops the bus; one pop lets exactly one more request out
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1'b0);
    chk("full_xfers", sb.size(), 4);
    chk("full_fill", f64.fill_o, 4);
    chk("full_istb", f64.istb_o, 0);
    step(0, 1'b1);
    chk("pop1_istb", f64.istb_o, 1);
    chk("pop1_fill", f64.fill_o, 3);
    for (int i = 0; i < 5; i++) step(0, 1'b0);
    chk("refill_xfers", sb.size(), 4);
    chk("refill_fill", f64.fill_o, 4);
    chk("refill_istb", f64.istb_o, 0);
    // redirect during a wait state squashes the in-flight response
    do_reset();
    tick();
    f64.inst_ready_i = 1'b1;
    f64.redirect_i = 1'b1;
    f64.redirect_pc_i = 64'h1003;
    tick();
    f64.redirect_i = 1'b0;
    chk("sq_hold_istb", f64.istb_o, 1);
    chk("sq_hold_iadr", f64.iadr_o, H);
    tick();
    tick();
    chk("sq_hold2_iadr", f64.iadr_o, H);
    f64.iack_i = 1'b1;
    f64.idat_i = 32'hDEAD_BEEF;
    tick();
    idle();
    chk("sq_istb", f64.istb_o, 1);
    chk("sq_iadr", f64.iadr_o, 64'h1000);
    chk("sq_fill", f64.fill_o, 0);
    chk("sq_valid", f64.inst_valid_o, 0);
    mpc = 64'h1000;
    w = 0;
    step(0, 1'b1);
    chk("sq_first_pc", f64.inst_pc_o, 64'h1000);
    step(0, 1'b1);
    // redirect on the ack cycle, then a bus error halts fetch until the next redirect
    do_reset();
    tick();
    f64.iack_i = 1'b1;
    f64.idat_i = 32'h1234_5678;
    f64.redirect_i = 1'b1;
    f64.redirect_pc_i = 64'h2000;
    tick();
    idle();
    chk("rda_istb", f64.istb_o, 1);
    chk("rda_iadr", f64.iadr_o, 64'h2000);
    chk("rda_fill", f64.fill_o, 0);
    f64.ierr_i = 1'b1;
    f64.idat_i = 32'hFFFF_FFFF;
    tick();
    idle();
    chk("err_istb", f64.istb_o, 0);
    chk("err_valid", f64.inst_valid_o, 1);
    chk("err_flag", f64.inst_err_o, 1);
    chk("err_inst", f64.inst_o, 0);
    chk("err_pc", f64.inst_pc_o, 64'h2000);
    chk("err_fill", f64.fill_o, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (f64.istb_o) cnt++;
    end
    chk("halt_no_istb", cnt, 0);
    f64.redirect_i = 1'b1;
    f64.redirect_pc_i = 64'h3000;
    tick();
    idle();
    chk("resume_fill", f64.fill_o, 0);
    chk("resume_istb", f64.istb_o, 1);
    chk("resume_iadr", f64.iadr_o, 64'h3000);
    mpc = 64'h3000;
    w = 0;
    step(0, 1'b1);
    step(0, 1'b1);
    // redirect together with ack and pop at fill 3 drops everything
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) step(0, 1'b0);
    chk("f3_fill", f64.fill_o, 3);
    f64.iack_i = 1'b1;
    f64.idat_i = 32'hCAFE_0000;
    f64.inst_ready_i = 1'b1;
    f64.redirect_i = 1'b1;
    f64.redirect_pc_i = 64'h4000;
    tick();
    idle();
    chk("f3_rd_fill", f64.fill_o, 0);
    chk("f3_rd_valid", f64.inst_valid_o, 0);
    chk("f3_rd_iadr", f64.iadr_o, 64'h4000);
    sb.delete();
    mpc = 64'h4000;
    w = 0;
    for (int i = 0; i < 3; i++) step(0, 1'b1);
    // 32-bit PC wrap and reset mid-transfer
    rst32 = 1'b0;
    tick();
    chk("x32_iadr0", f32.iadr_o, 32'hFFFF_FFF8);
    f32.iack_i = 1'b1;
    f32.idat_i = 32'h0000_0001;
    tick();
    chk("x32_iadr1", f32.iadr_o, 32'hFFFF_FFFC);
    tick();
    f32.iack_i = 1'b0;
    chk("x32_wrap", f32.iadr_o, 0);
    chk("x32_istb", f32.istb_o, 1);
    chk("x32_fill", f32.fill_o, 2);
    chk("x32_pc", f32.inst_pc_o, 32'hFFFF_FFF8);
    rst32 = 1'b1;
    tick();
    chk("x32_rst_icyc", f32.icyc_o, 0);
    chk("x32_rst_fill", f32.fill_o, 0);
    f32.iack_i = 1'b1;
    tick();
    f32.iack_i = 1'b0;
    rst32 = 1'b0;
    tick();
    chk("x32_rel_fill", f32.fill_o, 0);
    chk("x32_rel_iadr", f32.iadr_o, 32'hFFFF_FFF8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
